// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and issues one request at a time to a variable-latency
// instruction memory, presenting the fetched word with InstrValid to the core.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned TIMEOUT      = 16,
    parameter logic [31:0] NOP_WORD     = 32'hE1A0_0000
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        WAIT,
        EXEC
    } state_t;

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   next_pc;
    logic          unused_bits;

    // Branch targets are word aligned; the low bits of Result never reach the PC
    assign next_pc     = PCSrc ? {Result[31:2], 2'b00} : PC + 32'd4;
    assign PCPlus8     = PC + 32'd8;
    assign unused_bits = ^Result[1:0];

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= BOOT;
            PC         <= RESET_VECTOR;
            Instr      <= NOP_WORD;
            InstrValid <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= 32'h0;
            FetchErr   <= 1'b0;
            cnt        <= '0;
        end else begin
            unique case (state)
                BOOT: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= PC;
                end
                FETCH: begin
                    state    <= WAIT;
                    imem_req <= 1'b0;
                    cnt      <= '0;
                end
                WAIT: begin
                    // Data arriving on the timeout cycle still wins
                    if (imem_rvalid) begin
                        Instr      <= imem_rdata;
                        InstrValid <= 1'b1;
                        state      <= EXEC;
                    end else if (cnt == CNT_MAX) begin
                        Instr      <= NOP_WORD;
                        FetchErr   <= 1'b1;
                        InstrValid <= 1'b1;
                        state      <= EXEC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (!Stall) begin
                        PC         <= next_pc;
                        imem_req   <= 1'b1;
                        imem_addr  <= next_pc;
                        InstrValid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences for reset and
// timeout corners, and randomized fetches checked against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int          TO  = 16;
    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        PCSrc;
    logic [31:0] Result;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic        FetchErr;

    int tests = 0;
    int fails = 0;

    instr_fetch_unit dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .PCSrc(PCSrc),
        .Result(Result),
        .Stall(Stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .Instr(Instr),
        .InstrValid(InstrValid),
        .PC(PC),
        .PCPlus8(PCPlus8),
        .FetchErr(FetchErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          lat;
        int          stl;
        logic        psrc;
        logic [31:0] res;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    logic [31:0] mpc;
    logic        merr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // lat: cycles from request to rvalid (0 = never answers)
    task automatic do_instr(input int lat, input int stl, input logic psrc,
                            input logic [31:0] res, input logic [31:0] rdata,
                            input logic [31:0] eaddr, input logic [31:0] einstr,
                            input logic eerr);
        int n;
        int ew;
        n = 0;
        while (!imem_req && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
        chk("req_addr", imem_addr, eaddr);
        chk("pc_at_req", PC, eaddr);
        chk("pcplus8", PCPlus8, 32'(eaddr + 32'd8));
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (InstrValid || n > 40) break;
            chk("no_req_in_wait", 32'(imem_req), 32'd0);
            if (n == lat) begin
                imem_rvalid = 1'b1;
                imem_rdata  = rdata;
            end
        end
        ew = (lat >= 1 && lat <= TO) ? lat + 1 : TO + 1;
        chk("wait_cycles", 32'(n), 32'(ew));
        chk("instr", Instr, einstr);
        chk("pc_exec", PC, eaddr);
        chk("fetch_err", 32'(FetchErr), 32'(eerr));
        for (int s = 1; s <= stl; s++) begin
            Stall  = 1'b1;
            PCSrc  = s[0];
            Result = $urandom;
            if (lat == 0 && s == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hBAD0_BAD0;
            end
            @(negedge CLK);
            imem_rvalid = 1'b0;
            chk("stall_instr", Instr, einstr);
            chk("stall_pc", PC, eaddr);
            chk("stall_no_req", 32'(imem_req), 32'd0);
            chk("stall_valid", 32'(InstrValid), 32'd1);
        end
        Stall  = 1'b0;
        PCSrc  = psrc;
        Result = res;
        @(negedge CLK);
        PCSrc  = 1'b0;
        chk("req_after_exec", 32'(imem_req), 32'd1);
        chk("valid_drop", 32'(InstrValid), 32'd0);
    endtask

    task automatic rand_instr(input logic force_br, input logic [31:0] br_res);
        int          lat;
        int          stl;
        logic        psrc;
        logic [31:0] res;
        logic [31:0] rd;
        logic [31:0] ein;
        lat  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
        stl  = int'($urandom_range(0, 3));
        psrc = force_br ? 1'b1 : 1'($urandom_range(0, 1));
        res  = force_br ? br_res : $urandom;
        rd   = $urandom;
        ein  = (lat >= 1 && lat <= TO) ? rd : NOP;
        if (lat == 0) merr = 1'b1;
        do_instr(lat, stl, psrc, res, rd, mpc, ein, merr);
        mpc = psrc ? (res & ~32'd3) : mpc + 32'd4;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 0, 1'b0, 32'h0, 32'hE3A0_1005, 32'h0000_0000, 32'hE3A0_1005, 1'b0};
        tbl[1] = '{1, 0, 1'b0, 32'h0, 32'h1111_1111, 32'h0000_0004, 32'h1111_1111, 1'b0};
        tbl[2] = '{3, 0, 1'b0, 32'h0, 32'h2222_2222, 32'h0000_0008, 32'h2222_2222, 1'b0};
        tbl[3] = '{16, 0, 1'b0, 32'h0, 32'h3333_3333, 32'h0000_000C, 32'h3333_3333, 1'b0};
        tbl[4] = '{2, 0, 1'b1, 32'h0000_0103, 32'h4444_4444, 32'h0000_0010, 32'h4444_4444, 1'b0};
        tbl[5] = '{1, 5, 1'b0, 32'h0, 32'h5555_5555, 32'h0000_0100, 32'h5555_5555, 1'b0};
        tbl[6] = '{1, 0, 1'b1, 32'hFFFF_FFFF, 32'h6666_6666, 32'h0000_0104, 32'h6666_6666, 1'b0};
        tbl[7] = '{4, 1, 1'b0, 32'h0, 32'h7777_7777, 32'hFFFF_FFFC, 32'h7777_7777, 1'b0};
        tbl[8] = '{1, 2, 1'b1, 32'h0000_0022, 32'h8888_8888, 32'h0000_0000, 32'h8888_8888, 1'b0};
        tbl[9] = '{0, 3, 1'b0, 32'h0, 32'h9999_9999, 32'h0000_0020, NOP, 1'b1};

        RESETn      = 1'b0;
        Stall       = 1'b0;
        PCSrc       = 1'b0;
        Result      = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        repeat (3) @(negedge CLK);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, NOP);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_err", 32'(FetchErr), 32'd0);
        chk("rst_pcplus8", PCPlus8, 32'h8);

        // BOOT occupies the cycle of release; request appears in the next one
        RESETn = 1'b1;
        chk("boot_no_req", 32'(imem_req), 32'd0);
        @(negedge CLK);
        chk("boot_req", 32'(imem_req), 32'd1);

        for (int i = 0; i < 10; i++)
            do_instr(tbl[i].lat, tbl[i].stl, tbl[i].psrc, tbl[i].res,
                     tbl[i].rdata, tbl[i].addr, tbl[i].instr, tbl[i].err);

        mpc  = 32'h0000_0024;
        merr = 1'b1;
        for (int i = 0; i < 50; i++) rand_instr(1'b0, 32'h0);
        rand_instr(1'b1, 32'h0000_0020);

        // Reset during WAIT at PC=0x20, with a stray response after release
        while (!imem_req) @(negedge CLK);
        chk("mid_addr", imem_addr, 32'h20);
        @(negedge CLK);
        RESETn = 1'b0;
        #1;
        chk("mid_rst_pc", PC, 32'h0);
        chk("mid_rst_instr", Instr, NOP);
        chk("mid_rst_valid", 32'(InstrValid), 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_err", 32'(FetchErr), 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        chk("mid_fetch_req", 32'(imem_req), 32'd1);
        chk("mid_fetch_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge CLK);
        imem_rvalid = 1'b0;
        chk("stray_ignored", 32'(InstrValid), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hE3A0_2007;
        @(negedge CLK);
        imem_rvalid = 1'b0;
        chk("post_rst_valid", 32'(InstrValid), 32'd1);
        chk("post_rst_instr", Instr, 32'hE3A0_2007);
        chk("post_rst_pc", PC, 32'h0);
        @(negedge CLK);

        mpc  = 32'h0000_0004;
        merr = 1'b0;
        for (int i = 0; i < 15; i++) rand_instr(1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
